// File: rtl/pmod_da2_pkg.sv
// Shared definitions for the PmodDA2 dual-DAC serial transmitter.
// Holds the state encoding, the frame geometry and the frame-packing helper.
// The top level and the per-channel shifter both use this package.
package pmod_da2_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_FRONT_PORCH = 3'd1,
    S_SHIFTING    = 3'd2,
    S_BACK_PORCH  = 3'd3,
    S_HOLD        = 3'd4
  } state_t;

  localparam int BITS_PER_FRAME = 16;
  localparam int PD_MSB         = 13;
  localparam int PD_LSB         = 12;
  localparam int DATA_MSB       = 11;

  // DAC121S101 frame: two don't-care zeros, power-down mode, 12-bit code.
  function automatic logic [BITS_PER_FRAME-1:0] make_frame(
    input logic [1:0]        pd,
    input logic [DATA_MSB:0] din
  );
    logic [BITS_PER_FRAME-1:0] f;
    f                = '0;
    f[PD_MSB:PD_LSB] = pd;
    f[DATA_MSB:0]    = din;
    return f;
  endfunction

endpackage

// File: rtl/pmod_da2_shifter.sv
// Purpose: 16-bit load/shift register presenting its MSB as the serial data line.
// Latency: a load or shift is visible on sdout the cycle after the enabling edge.
// Backpressure: none; the controlling FSM decides when to load and shift.
module pmod_da2_shifter
  import pmod_da2_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      shift,
  input  logic [BITS_PER_FRAME-1:0] frame,
  output logic                      sdout
);

  logic [BITS_PER_FRAME-1:0] shft;

  // Load a fresh frame on accept, otherwise move the next bit up to the MSB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shft <= '0;
    end else if (load) begin
      shft <= frame;
    end else if (shift) begin
      shft <= {shft[BITS_PER_FRAME-2:0], 1'b0};
    end
  end

  assign sdout = shft[BITS_PER_FRAME-1];

endmodule

// File: rtl/pmod_da2_spi_tx.sv
// Purpose: serialise one pair of 12-bit samples into two simultaneous DAC121S101 frames.
// Latency: sync falls the cycle after accept; done pulses and ready returns at fixed frame-length offsets.
// Backpressure: ready is high only while idle; valid is ignored otherwise and must be held by the source.
module pmod_da2_spi_tx
  import pmod_da2_pkg::*;
#(
  parameter int CLOCKS_PER_BIT              = 20,
  parameter int CLOCKS_BEFORE_DATA          = 10,
  parameter int CLOCKS_AFTER_DATA           = 10,
  parameter int CLOCKS_BETWEEN_TRANSACTIONS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_MSB:0] din0,
  input  logic [DATA_MSB:0] din1,
  input  logic [1:0]        pd0,
  input  logic [1:0]        pd1,
  input  logic              valid,
  output logic              ready,
  output logic              done,
  output logic              sync,
  output logic              sclk,
  output logic              sdout0,
  output logic              sdout1
);

  // One phase counter serves every state, so size it for the longest phase.
  localparam int MAX_A   = (CLOCKS_PER_BIT > CLOCKS_BEFORE_DATA) ? CLOCKS_PER_BIT : CLOCKS_BEFORE_DATA;
  localparam int MAX_B   = (CLOCKS_AFTER_DATA > CLOCKS_BETWEEN_TRANSACTIONS) ?
                           CLOCKS_AFTER_DATA : CLOCKS_BETWEEN_TRANSACTIONS;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int BIT_W   = $clog2(BITS_PER_FRAME);

  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SCLK_HALF  = CNT_W'(CLOCKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FP_LAST    = CNT_W'(CLOCKS_BEFORE_DATA - 1);
  localparam logic [CNT_W-1:0] BP_LAST    = CNT_W'(CLOCKS_AFTER_DATA - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CLOCKS_BETWEEN_TRANSACTIONS - 1);
  localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(BITS_PER_FRAME - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count0;
  logic [BIT_W-1:0]   count1;
  logic               load_frame;
  logic               shift_bit;
  logic               done_nxt;

  // State and the registered completion pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Phase counter (count0) and bit counter (count1); both restart on every state change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count0 <= '0;
      count1 <= '0;
    end else if (state_nxt != state) begin
      count0 <= '0;
      count1 <= '0;
    end else if (state == S_SHIFTING && count0 == BIT_LAST) begin
      count0 <= '0;
      count1 <= count1 + BIT_W'(1);
    end else if (state != S_IDLE) begin
      count0 <= count0 + CNT_W'(1);
    end
  end

  // Next-state and pin decode; sclk idles high and only runs while shifting.
  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    sync       = 1'b0;
    sclk       = 1'b1;
    load_frame = 1'b0;
    shift_bit  = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        sync  = 1'b1;
        if (valid) begin
          load_frame = 1'b1;
          state_nxt  = S_FRONT_PORCH;
        end
      end
      S_FRONT_PORCH: begin
        if (count0 == FP_LAST) begin
          state_nxt = S_SHIFTING;
        end
      end
      S_SHIFTING: begin
        sclk = (count0 < SCLK_HALF);
        if (count0 == BIT_LAST) begin
          // Advance data at the rising boundary so it is centred on the falling edge.
          shift_bit = 1'b1;
          if (count1 == FRAME_LAST) begin
            state_nxt = S_BACK_PORCH;
          end
        end
      end
      S_BACK_PORCH: begin
        if (count0 == BP_LAST) begin
          state_nxt = S_HOLD;
          done_nxt  = 1'b1;
        end
      end
      S_HOLD: begin
        sync = 1'b1;
        if (count0 == HOLD_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  pmod_da2_shifter u_shift0 (
    .clk   (clk),
    .rst   (rst),
    .load  (load_frame),
    .shift (shift_bit),
    .frame (make_frame(pd0, din0)),
    .sdout (sdout0)
  );

  pmod_da2_shifter u_shift1 (
    .clk   (clk),
    .rst   (rst),
    .load  (load_frame),
    .shift (shift_bit),
    .frame (make_frame(pd1, din1)),
    .sdout (sdout1)
  );

endmodule

// File: tb/tb_pmod_da2_spi_tx.sv
// Directed bench for the PmodDA2 transmitter: default-timing instance plus a minimum-timing instance.
// Expected frames and cycle counts are hand-computed constants.
// Pin activity is recorded by per-instance monitors and compared from the main sequence.
module tb_pmod_da2_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] din0, din1;
  logic [1:0]  pd0, pd1;
  logic        valid;
  logic        ready, done, sync, sclk, sdout0, sdout1;

  logic [11:0] b_din0, b_din1;
  logic [1:0]  b_pd0, b_pd1;
  logic        b_valid;
  logic        b_ready, b_done, b_sync, b_sclk, b_sdout0, b_sdout1;

  pmod_da2_spi_tx dut (
    .clk(clk), .rst(rst), .din0(din0), .din1(din1), .pd0(pd0), .pd1(pd1),
    .valid(valid), .ready(ready), .done(done), .sync(sync), .sclk(sclk),
    .sdout0(sdout0), .sdout1(sdout1)
  );

  pmod_da2_spi_tx #(
    .CLOCKS_PER_BIT(2), .CLOCKS_BEFORE_DATA(1), .CLOCKS_AFTER_DATA(1),
    .CLOCKS_BETWEEN_TRANSACTIONS(1)
  ) dut_b (
    .clk(clk), .rst(rst), .din0(b_din0), .din1(b_din1), .pd0(b_pd0), .pd1(b_pd1),
    .valid(b_valid), .ready(b_ready), .done(b_done), .sync(b_sync), .sclk(b_sclk),
    .sdout0(b_sdout0), .sdout1(b_sdout1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor for the default-timing instance ----------------
  int          cyc = 0, acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0, rdy_cyc = 0;
  logic [15:0] cap0 = '0, cap1 = '0;
  int          falls = 0, low_len = 0, last_fall = 0, lo_run = 0;
  int          lo_min = 999, lo_max = 0, per_min = 999, per_max = 0;
  int          hi_len = 0, gap_min = 999, frames_ended = 0, idle_toggle = 0, sd_bad = 0;
  bit          aborted = 1'b0;
  logic        p_sclk = 1'b1, p_sync = 1'b1, p_sd0 = 1'b0, p_sd1 = 1'b0, p_rdy = 1'b1;
  logic [15:0] got0_q[$], got1_q[$];
  int          falls_q[$], lowlen_q[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst && valid && ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (!rst) aborted = 1'b1;
    #1;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ready && !p_rdy) rdy_cyc = cyc;
    if (sync && p_sync && (sclk !== p_sclk)) idle_toggle++;
    if (!sclk && ((sdout0 !== p_sd0) || (sdout1 !== p_sd1))) sd_bad++;
    if (!sync) begin
      if (p_sync) begin
        if (frames_ended > 0 && hi_len < gap_min) gap_min = hi_len;
        falls = 0; low_len = 0; cap0 = '0; cap1 = '0; aborted = 1'b0; lo_run = 0;
      end
      low_len++;
      if (p_sclk && !sclk) begin
        falls++;
        cap0 = {cap0[14:0], sdout0};
        cap1 = {cap1[14:0], sdout1};
        if (falls > 1) begin
          if (cyc - last_fall < per_min) per_min = cyc - last_fall;
          if (cyc - last_fall > per_max) per_max = cyc - last_fall;
        end
        last_fall = cyc;
      end
      if (!sclk) lo_run++;
      else if (!p_sclk) begin
        if (lo_run < lo_min) lo_min = lo_run;
        if (lo_run > lo_max) lo_max = lo_run;
        lo_run = 0;
      end
    end else begin
      if (!p_sync) begin
        if (!aborted) begin
          got0_q.push_back(cap0);
          got1_q.push_back(cap1);
          falls_q.push_back(falls);
          lowlen_q.push_back(low_len);
        end
        frames_ended++;
        hi_len = 0;
      end
      hi_len++;
    end
    p_sclk = sclk; p_sync = sync; p_sd0 = sdout0; p_sd1 = sdout1; p_rdy = ready;
  end

  // ---------------- monitor for the minimum-timing instance ----------------
  int          b_cyc = 0, b_acc_cyc = 0, b_done_cyc = 0, b_rdy_cyc = 0, b_frames = 0;
  logic [15:0] b_cap0 = '0, b_cap1 = '0, b_got0 = '0, b_got1 = '0;
  int          b_falls = 0, b_low = 0, b_last_fall = 0, b_per_min = 999, b_per_max = 0;
  int          b_got_falls = 0, b_got_low = 0;
  logic        b_p_sclk = 1'b1, b_p_sync = 1'b1, b_p_rdy = 1'b1;

  always @(posedge clk) begin
    b_cyc = b_cyc + 1;
    if (rst && b_valid && b_ready) b_acc_cyc = b_cyc;
    #1;
    if (b_done) b_done_cyc = b_cyc;
    if (b_ready && !b_p_rdy) b_rdy_cyc = b_cyc;
    if (!b_sync) begin
      if (b_p_sync) begin
        b_falls = 0; b_low = 0; b_cap0 = '0; b_cap1 = '0;
      end
      b_low++;
      if (b_p_sclk && !b_sclk) begin
        b_falls++;
        b_cap0 = {b_cap0[14:0], b_sdout0};
        b_cap1 = {b_cap1[14:0], b_sdout1};
        if (b_falls > 1) begin
          if (b_cyc - b_last_fall < b_per_min) b_per_min = b_cyc - b_last_fall;
          if (b_cyc - b_last_fall > b_per_max) b_per_max = b_cyc - b_last_fall;
        end
        b_last_fall = b_cyc;
      end
    end else if (!b_p_sync) begin
      b_got0 = b_cap0; b_got1 = b_cap1; b_got_falls = b_falls; b_got_low = b_low;
      b_frames++;
    end
    b_p_sclk = b_sclk; b_p_sync = b_sync; b_p_rdy = b_ready;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [11:0] d0, input logic [1:0] p0,
                      input logic [11:0] d1, input logic [1:0] p1);
    int t;
    t = 0;
    @(negedge clk);
    din0 = d0; pd0 = p0; din1 = d1; pd1 = p1; valid = 1'b1;
    while (!ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    // Scramble the inputs after the accept edge; the frame in flight must not see this.
    valid = 1'b0; din0 = 12'hEEE; din1 = 12'h111; pd0 = 2'b11; pd1 = 2'b11;
  endtask

  task automatic wait_frame(input int n);
    int t;
    t = 0;
    while (got0_q.size() < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check("frame_arrived", (got0_q.size() >= n), 1'b1);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("ready_returned", ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a0;
    int t;
    rst = 1'b0; valid = 1'b0; din0 = '0; din1 = '0; pd0 = '0; pd1 = '0;
    b_valid = 1'b0; b_din0 = '0; b_din1 = '0; b_pd0 = '0; b_pd1 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_sync", sync, 1'b1);
    check("rst_sclk", sclk, 1'b1);
    check("rst_sdout0", sdout0, 1'b0);
    check("rst_sdout1", sdout1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame with default timing
    send(12'hABC, 2'b00, 12'h123, 2'b11);
    wait_frame(1);
    check("f1_ch0", got0_q[0], 16'h0ABC);
    check("f1_ch1", got1_q[0], 16'h3123);
    check("f1_falls", falls_q[0], 16);
    check("f1_sync_low", lowlen_q[0], 340);
    check("f1_done_lat", done_cyc - acc_cyc, 340);
    check("f1_done_cnt", done_cnt, 1);
    wait_ready();
    check("f1_ready_lat", rdy_cyc - acc_cyc, 350);
    check("sclk_low_min", lo_min, 10);
    check("sclk_low_max", lo_max, 10);
    check("sclk_per_min", per_min, 20);
    check("sclk_per_max", per_max, 20);

    // valid held high while din changes every cycle: accepts at stream cycles 0 and 351
    a0 = acc_cnt;
    @(negedge clk);
    valid = 1'b1;
    for (int k = 0; k < 360; k++) begin
      din0 = 12'h100 + 12'(k);
      din1 = 12'h800 + 12'(k);
      pd0 = 2'b00; pd1 = 2'b01;
      @(negedge clk);
    end
    valid = 1'b0;
    check("stream_accepts", acc_cnt - a0, 2);
    wait_frame(3);
    check("s1_ch0", got0_q[1], 16'h0100);
    check("s1_ch1", got1_q[1], 16'h1800);
    check("s2_ch0", got0_q[2], 16'h025F);
    check("s2_ch1", got1_q[2], 16'h195F);
    check("s2_falls", falls_q[2], 16);
    check("gap_min", gap_min, 11);
    wait_ready();

    // Reset during bit 7 (low half of the bit period)
    send(12'h555, 2'b00, 12'hAAA, 2'b00);
    repeat (165) @(negedge clk);
    check("pre_rst_sclk", sclk, 1'b0);
    check("pre_rst_sdout0", sdout0, 1'b1);
    check("pre_rst_sync", sync, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("mid_rst_sync", sync, 1'b1);
    check("mid_rst_sclk", sclk, 1'b1);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_sdout0", sdout0, 1'b0);
    check("mid_rst_sdout1", sdout1, 1'b0);
    check("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_dropped", got0_q.size(), 3);
    send(12'hFFF, 2'b00, 12'h000, 2'b00);
    wait_frame(4);
    check("r_ch0", got0_q[3], 16'h0FFF);
    check("r_ch1", got1_q[3], 16'h0000);
    check("r_falls", falls_q[3], 16);
    wait_ready();

    // Boundary data and pd codes
    send(12'h000, 2'b10, 12'hFFF, 2'b01);
    wait_frame(5);
    check("b_ch0", got0_q[4], 16'h2000);
    check("b_ch1", got1_q[4], 16'h1FFF);
    check("b_falls", falls_q[4], 16);
    wait_ready();
    check("done_total", done_cnt, 5);
    check("sdout_chg_sclk_low", sd_bad, 0);
    check("sclk_toggle_sync_hi", idle_toggle, 0);

    // Minimum-timing instance
    @(negedge clk);
    b_din0 = 12'h5A5; b_pd0 = 2'b01; b_din1 = 12'h3C3; b_pd1 = 2'b10; b_valid = 1'b1;
    t = 0;
    while (!b_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    b_valid = 1'b0; b_din0 = 12'h000; b_din1 = 12'hFFF;
    t = 0;
    while (b_frames < 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("fast_frames", b_frames, 1);
    check("fast_ch0", b_got0, 16'h15A5);
    check("fast_ch1", b_got1, 16'h23C3);
    check("fast_falls", b_got_falls, 16);
    check("fast_sync_low", b_got_low, 34);
    check("fast_per_min", b_per_min, 2);
    check("fast_per_max", b_per_max, 2);
    check("fast_done_lat", b_done_cyc - b_acc_cyc, 34);
    check("fast_ready_lat", b_rdy_cyc - b_acc_cyc, 35);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
